// File: rtl/accum_pkg.sv
// Shared definitions for the multi-channel accumulator: operation encoding.
package accum_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD   = 2'b00;
    localparam op_t OP_SUB   = 2'b01;
    localparam op_t OP_LOAD  = 2'b10;
    localparam op_t OP_CLEAR = 2'b11;

endpackage

// File: rtl/addsub_flags.sv
// Combinational N-bit adder/subtractor with unsigned carry (no-borrow on SUB)
// and signed overflow.
module addsub_flags #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] r,
    output logic         carry,
    output logic         overflow
);

    logic [N-1:0] b_eff;
    logic [N:0]   sum;

    always_comb begin
        b_eff    = sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
        r        = sum[N-1:0];
        carry    = sum[N];
        // Overflow: both effective operand signs agree but the result sign differs.
        overflow = (a[N-1] == b_eff[N-1]) && (r[N-1] != a[N-1]);
    end

endmodule

// File: rtl/accum_channel_bank.sv
// CH-channel N-bit accumulator bank, two-stage pipeline with same-channel
// forwarding, optional signed saturation and per-channel sticky overflow.
module accum_channel_bank
    import accum_pkg::*;
#(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] in_ch,
    input  logic [1:0]    in_op,
    input  logic [N-1:0]  in_data,
    input  logic          sat_en,
    input  logic          flag_clr,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [N-1:0]  out_sum,
    output logic          out_carry,
    output logic          out_overflow,
    output logic [CH-1:0] sticky_ovf
);

    logic [N-1:0]  bank_q [CH];
    logic [N-1:0]  bank_d [CH];

    logic          s1_valid_q, s1_valid_d;
    op_t           s1_op_q, s1_op_d;
    logic [CW-1:0] s1_ch_q, s1_ch_d;
    logic [N-1:0]  s1_data_q, s1_data_d;
    logic          s1_sat_q, s1_sat_d;
    logic [N-1:0]  s1_acc_q, s1_acc_d;

    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic [N-1:0]  out_sum_q, out_sum_d;
    logic          out_carry_q, out_carry_d;
    logic          out_ovf_q, out_ovf_d;
    logic [CH-1:0] sticky_q, sticky_d;

    logic [N-1:0]  as_r;
    logic          as_carry, as_ovf;
    logic [N-1:0]  res;
    logic          res_carry, res_ovf;
    logic          ch_ok;

    addsub_flags #(.N(N)) u_addsub (
        .a        (s1_acc_q),
        .b        (s1_data_q),
        .sub      (s1_op_q == OP_SUB),
        .r        (as_r),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    // Stage 2 result; flags report the raw arithmetic even when saturated.
    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_SUB: begin
                res       = as_r;
                res_carry = as_carry;
                res_ovf   = as_ovf;
                if (s1_sat_q && as_ovf) begin
                    res = s1_acc_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                end
            end
            OP_LOAD: res = s1_data_q;
            default: res = '0;
        endcase
    end

    // Stage 1 capture; the operand read takes the stage-2 result when it targets the same channel.
    always_comb begin
        ch_ok    = 1'b0;
        s1_acc_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == CW'(i)) begin
                ch_ok    = 1'b1;
                s1_acc_d = bank_q[i];
            end
        end
        if (s1_valid_q && (s1_ch_q == in_ch)) begin
            s1_acc_d = res;
        end
        s1_valid_d = in_valid && ch_ok;
        s1_op_d    = in_op;
        s1_ch_d    = in_ch;
        s1_data_d  = in_data;
        s1_sat_d   = sat_en;
    end

    always_comb begin
        bank_d      = bank_q;
        sticky_d    = flag_clr ? '0 : sticky_q;
        out_valid_d = s1_valid_q;
        out_ch_d    = out_ch_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        if (s1_valid_q) begin
            out_ch_d    = s1_ch_q;
            out_sum_d   = res;
            out_carry_d = res_carry;
            out_ovf_d   = res_ovf;
            for (int i = 0; i < CH; i++) begin
                if (s1_ch_q == CW'(i)) begin
                    bank_d[i] = res;
                    if (s1_op_q == OP_CLEAR) begin
                        sticky_d[i] = 1'b0;
                    end
                    // Setting after the clears makes a simultaneous set win.
                    if (res_ovf) begin
                        sticky_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q      <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_ch_q     <= '0;
            s1_data_q   <= '0;
            s1_sat_q    <= 1'b0;
            s1_acc_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            sticky_q    <= '0;
        end else begin
            bank_q      <= bank_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_ch_q     <= s1_ch_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            s1_acc_q    <= s1_acc_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_ch       = out_ch_q;
    assign out_sum      = out_sum_q;
    assign out_carry    = out_carry_q;
    assign out_overflow = out_ovf_q;
    assign sticky_ovf   = sticky_q;

endmodule

// File: tb/tb_accum_channel_bank.sv
// Scoreboard bench for accum_channel_bank (N=8, CH=4): directed transactions
// push expected results, a negedge monitor pops and compares each output.
module tb_accum_channel_bank;
    import accum_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       sat_en;
    logic       flag_clr;
    logic       out_valid;
    logic [1:0] out_ch;
    logic [7:0] out_sum;
    logic       out_carry;
    logic       out_overflow;
    logic [3:0] sticky_ovf;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] sum;
        logic       c;
        logic       v;
        logic [3:0] st;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    accum_channel_bank #(.N(8), .CH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ch        (in_ch),
        .in_op        (in_op),
        .in_data      (in_data),
        .sat_en       (sat_en),
        .flag_clr     (flag_clr),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .sticky_ovf   (sticky_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: out_valid high at cycle %0d with sum %0h, required no output", cyc, out_sum);
            end else begin
                mon_e = sb.pop_front();
                chk("out_cycle", cyc, mon_e.cyc);
                chk("out_ch", {30'd0, out_ch}, {30'd0, mon_e.ch});
                chk("out_sum", {24'd0, out_sum}, {24'd0, mon_e.sum});
                chk("out_carry", {31'd0, out_carry}, {31'd0, mon_e.c});
                chk("out_overflow", {31'd0, out_overflow}, {31'd0, mon_e.v});
                chk("sticky_ovf", {28'd0, sticky_ovf}, {28'd0, mon_e.st});
            end
        end
    end

    task automatic tx(input logic [1:0] ch, input op_t op, input logic [7:0] d, input logic sat,
                      input logic [7:0] es, input logic ec, input logic ev, input logic [3:0] est);
        exp_t e;
        in_valid = 1'b1;
        in_ch    = ch;
        in_op    = op;
        in_data  = d;
        sat_en   = sat;
        e.ch  = ch;
        e.sum = es;
        e.c   = ec;
        e.v   = ev;
        e.st  = est;
        e.cyc = cyc + 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sat_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        in_ch    = '0;
        in_op    = OP_ADD;
        in_data  = '0;
        sat_en   = 1'b0;
        flag_clr = 1'b0;
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
        chk("rst_sticky", {28'd0, sticky_ovf}, 32'd0);

        // basic ADD with latency
        tx(2'd0, OP_ADD, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 4'b0000);
        tx(2'd0, OP_ADD, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 4'b0000);
        idle(3);

        // signed overflow, raw then saturated
        tx(2'd1, OP_ADD, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, 4'b0000);
        tx(2'd1, OP_ADD, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4'b0010);
        idle(3);
        tx(2'd1, OP_CLEAR, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        tx(2'd1, OP_ADD, 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b0, 4'b0000);
        tx(2'd1, OP_ADD, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 4'b0010);
        idle(3);

        // LOAD, SUB borrow, ADD carry
        tx(2'd2, OP_LOAD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0010);
        tx(2'd2, OP_SUB, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 4'b0010);
        tx(2'd2, OP_LOAD, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 4'b0010);
        tx(2'd2, OP_ADD, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0010);
        idle(3);

        // interleaved channels with back-to-back forwarding
        do_reset();
        tx(2'd0, OP_ADD, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 4'b0000);
        tx(2'd1, OP_ADD, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0, 4'b0000);
        tx(2'd0, OP_ADD, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 4'b0000);
        tx(2'd0, OP_ADD, 8'h08, 1'b0, 8'h0D, 1'b0, 1'b0, 4'b0000);
        idle(3);

        // sticky: set beats flag_clr on the same edge, CLEAR drops the bit
        tx(2'd1, OP_ADD, 8'h7F, 1'b0, 8'h81, 1'b0, 1'b1, 4'b0010);
        idle(2);
        tx(2'd3, OP_ADD, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, 4'b0010);
        tx(2'd3, OP_ADD, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4'b1000);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        idle(2);
        tx(2'd3, OP_CLEAR, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        idle(3);
        chk("sticky_after_clear", {28'd0, sticky_ovf}, 32'd0);

        // reset with transactions in flight: nothing may come out
        in_valid = 1'b1;
        in_ch    = 2'd2;
        in_op    = OP_ADD;
        in_data  = 8'h11;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        in_ch   = 2'd3;
        in_data = 8'h22;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        idle(3);
        tx(2'd0, OP_ADD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        tx(2'd1, OP_ADD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        tx(2'd2, OP_ADD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        tx(2'd3, OP_ADD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000);
        idle(4);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accum_channel_bank.md
# accum_channel_bank

Multi-channel, parametrised accumulator. It holds CH independent N-bit running sums and accepts one add/subtract/load/clear transaction per cycle. Each result is returned with carry and signed-overflow flags, optionally saturated, and per-channel sticky overflow is kept. It sits between the switch/key input logic and the hex display/LED drivers, replacing the single-channel add-only accumulator.

## Interface
Parameters:
- N, 8, accumulator and data width (≥2)
- CH, 4, number of channels (≥1); CW = max(1, $clog2(CH))

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  transaction strobe, accepted every cycle (no backpressure)
- in_ch  in  CW  target channel; values ≥ CH ignored (transaction dropped)
- in_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
- in_data  in  N  operand
- sat_en  in  1  signed saturation enable, sampled with the transaction
- flag_clr  in  1  clears all sticky overflow bits
- out_valid  out  1  result strobe, one cycle per accepted transaction
- out_ch  out  CW  channel of the result
- out_sum  out  N  new accumulator value
- out_carry  out  1  unsigned carry out (ADD) / no-borrow (SUB)
- out_overflow  out  1  signed overflow of this operation (pre-saturation)
- sticky_ovf  out  CH  per-channel sticky overflow

## Operation
- Two-stage pipeline:
  - S1 registers op/ch/data/sat_en and reads bank[ch].
  - S2 computes, writes bank[ch], and loads the output registers.
- ADD: {c, r} = acc + d.
- SUB: {c, r} = acc + ~d + 1; c = 1 means no borrow.
- Signed overflow: operands' effective signs equal and r sign differs (SUB uses ~d sign).
- Saturation: if sat_en and overflow, r = 0x7F..F when acc is non-negative, else 0x80..0. out_carry and out_overflow still report raw values.
- LOAD: r = d, carry = 0, overflow = 0.
- CLEAR: r = 0, carry = 0, overflow = 0; also clears sticky_ovf[ch].
- Reading a channel without changing it is done with ADD 0.
- Hazard: if S2 writes the same channel S1 is reading, S1 uses S2's result (forwarding). Back-to-back same-channel transactions must behave exactly as if serialised.
- Sticky:
  - Set on an overflowing ADD/SUB.
  - flag_clr clears all bits.
  - When a set and a clear hit the same bit in the same cycle, set wins.
  - CLEAR of a channel clears its bit.
- in_ch ≥ CH: the transaction produces no write and no out_valid.

## Timing
- Latency 2: a transaction accepted at edge t produces out_valid high in the cycle after edge t+1. Bank update is visible to a transaction accepted at edge t+1 via forwarding.
- Throughput 1 per cycle, any channel mix.
- Outputs hold their last values when out_valid is low.
- Reset:
  - All bank entries, pipeline valid bits, out_* and sticky_ovf go to 0.
  - In-flight transactions are discarded; no out_valid for them.
  - Inputs are ignored during reset.
- sticky_ovf updates on the same edge as the corresponding out_valid data.

## Structure
- Package accum_pkg: op encoding constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR) and the 2-bit op type.
- One sub-module, addsub_flags: combinational N-bit add/sub producing r, carry, overflow. It is parametrised by N and has no clock.
- Bank is a CH×N register array (no RAM inference required).

## Test plan
All scenarios use N=8, CH=4.
- Reset, then ch0 ADD 0x05 and ADD 0x03 on consecutive cycles → out_sum 0x05 then 0x08, carry 0, ovf 0, each out_valid 2 cycles after accept.
- ch1 ADD 0x7F, then ADD 0x01 with sat_en=0 → 0x7F, then 0x80 with ovf 1, carry 0, sticky_ovf=4'b0010. Repeat from CLEAR with sat_en=1 → 0x7F with ovf 1.
- ch2 LOAD 0x00, then SUB 0x01 → 0xFF with carry 0, ovf 0. Then LOAD 0x01 and ADD 0xFF → 0x00 with carry 1, ovf 0.
- Interleave ch0 ADD 1, ch1 ADD 2, ch0 ADD 4, ch0 ADD 8 back-to-back from reset → 0x01, 0x02, 0x05, 0x0D; forwarding verified.
- sticky_ovf[1]=1, then flag_clr asserted on the same edge as a new ch3 overflow → sticky_ovf=4'b1000. Then ch3 CLEAR → sticky_ovf=0 and out_sum 0.
- Two transactions in flight and reset asserted for 1 cycle → no out_valid for them; a subsequent ADD 0 on every channel returns 0x00.
